// File: rtl/systolic_writeback_if.sv
// Handshake and data bundle between the control FSM / array and the writeback stage.
// master drives start, results and FIFO full; slave (the writeback stage) drives FIFO writes and status.
interface systolic_writeback_if #(
    parameter int datawith   = 16,
    parameter int accwidth   = 32,
    parameter int array_size = 2
);
    localparam int NUM = array_size * array_size;

    logic                    write_start;
    logic [NUM*accwidth-1:0] result_bus;
    logic                    wfull;
    logic                    winc;
    logic [datawith-1:0]     wdata;
    logic                    write_done;
    logic                    busy;

    modport master (
        output write_start,
        output result_bus,
        output wfull,
        input  winc,
        input  wdata,
        input  write_done,
        input  busy
    );

    modport slave (
        input  write_start,
        input  result_bus,
        input  wfull,
        output winc,
        output wdata,
        output write_done,
        output busy
    );
endinterface

// File: rtl/systolic_writeback.sv
// Snapshots the array's NUM accumulators on a write_start rising edge and streams them to the output FIFO.
// Latency: first write one cycle after the start edge, write_done one cycle after the last write.
// Backpressure: wfull stalls the stream in place; SYSTOLIC_WB_SATURATE_EN selects saturating conversion.
module systolic_writeback #(
    parameter int datawith   = 16,
    parameter int accwidth   = 32,
    parameter int array_size = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    systolic_writeback_if.slave  bus
);
    localparam int NUM = array_size * array_size;
    localparam int CW  = (NUM > 1) ? $clog2(NUM) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_d;
    logic                start_q;
    logic [accwidth-1:0] buf_q [NUM];

    logic                start_edge;
    logic                fire;
    logic                last;
    logic [accwidth-1:0] cur_acc;
    logic [datawith-1:0] conv;

    assign start_edge = bus.write_start & ~start_q;
    assign fire       = (state_q == SEND) & ~bus.wfull;
    assign last       = (cnt_q == CW'(NUM - 1));
    assign cur_acc    = buf_q[cnt_q];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_edge) state_d = SEND;
            SEND:    if (fire && last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Element counter: advances only on an accepted write
    always_comb begin
        cnt_d = cnt_q;
        case (state_q)
            IDLE:    if (start_edge) cnt_d = '0;
            SEND:    if (fire) cnt_d = cnt_q + CW'(1);
            DONE:    cnt_d = '0;
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            start_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            start_q <= bus.write_start;
        end
    end

    // Snapshot is taken only on an accepted start, so later result_bus changes are invisible
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM; i++) buf_q[i] <= '0;
        end else if (state_q == IDLE && start_edge) begin
            for (int i = 0; i < NUM; i++) buf_q[i] <= bus.result_bus[i*accwidth +: accwidth];
        end
    end

`ifdef SYSTOLIC_WB_SATURATE_EN
    // In range when every bit above the datawith sign bit matches it
    logic [accwidth-datawith:0] acc_top;
    assign acc_top = cur_acc[accwidth-1:datawith-1];

    always_comb begin
        conv = cur_acc[datawith-1:0];
        if (!((&acc_top) || (~|acc_top))) begin
            conv = cur_acc[accwidth-1] ? {1'b1, {(datawith-1){1'b0}}}
                                       : {1'b0, {(datawith-1){1'b1}}};
        end
    end
`else
    assign conv = cur_acc[datawith-1:0];

    generate
        if (accwidth > datawith) begin : g_trunc
            logic unused_acc_hi;
            assign unused_acc_hi = ^cur_acc[accwidth-1:datawith];
        end
    endgenerate
`endif

    // Output logic
    always_comb begin
        bus.winc       = 1'b0;
        bus.wdata      = '0;
        bus.write_done = 1'b0;
        bus.busy       = 1'b0;
        case (state_q)
            SEND: begin
                bus.busy  = 1'b1;
                bus.winc  = ~bus.wfull;
                bus.wdata = conv;
            end
            DONE: begin
                bus.busy       = 1'b1;
                bus.write_done = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_systolic_writeback.sv
// Scoreboard bench for systolic_writeback: directed transfers, monitor pops expected words on every FIFO write.
module tb_systolic_writeback;
    localparam int DW  = 16;
    localparam int AW  = 32;
    localparam int AS  = 2;
    localparam int NUM = AS * AS;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    systolic_writeback_if #(.datawith(DW), .accwidth(AW), .array_size(AS)) wb_if ();

    systolic_writeback #(.datawith(DW), .accwidth(AW), .array_size(AS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (wb_if.slave)
    );

    int              n_checks = 0;
    int              n_fail   = 0;
    int              done_cnt = 0;
    int              wr_cnt   = 0;
    logic [DW-1:0]   sb [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every FIFO write must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (wb_if.write_done) done_cnt++;
            if (wb_if.winc) begin
                wr_cnt++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got 0x%0h, expected no write", wb_if.wdata);
                end else begin
                    logic [DW-1:0] expv;
                    expv = sb.pop_front();
                    check("wdata", {48'd0, wb_if.wdata}, {48'd0, expv});
                end
            end
        end
    end

    task automatic load(input logic [AW-1:0] e0, input logic [AW-1:0] e1,
                        input logic [AW-1:0] e2, input logic [AW-1:0] e3);
        wb_if.result_bus = {e3, e2, e1, e0};
    endtask

    task automatic push(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [DW-1:0] d2, input logic [DW-1:0] d3);
        sb.push_back(d0);
        sb.push_back(d1);
        sb.push_back(d2);
        sb.push_back(d3);
    endtask

    // Counts negedges from the start request until write_done, then checks the pulse is single-cycle
    task automatic wait_done(input int exp_lat, input string name);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (wb_if.write_done) seen = 1;
        end
        check(name, n, exp_lat);
        @(negedge clk);
        check({name, "_done_low"}, wb_if.write_done, 0);
        check({name, "_busy_low"}, wb_if.busy, 0);
    endtask

    initial begin
        int d0;
        int w0;
        wb_if.write_start = 1'b0;
        wb_if.result_bus  = '0;
        wb_if.wfull       = 1'b0;
        rst = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_winc", wb_if.winc, 0);
        check("rst_wdata", wb_if.wdata, 0);
        check("rst_done", wb_if.write_done, 0);
        check("rst_busy", wb_if.busy, 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        // Basic drain, start pulsed for one cycle (falls during SEND)
        load(32'h1, 32'h2, 32'h3, 32'h4);
        push(16'h1, 16'h2, 16'h3, 16'h4);
        @(posedge clk); #1 wb_if.write_start = 1'b1;
        fork
            wait_done(NUM + 2, "lat_basic");
            begin @(posedge clk); #1 wb_if.write_start = 1'b0; end
        join
        check("busy_during_idle", wb_if.busy, 0);

        // Backpressure in the 2nd and 3rd SEND cycles
        push(16'h1, 16'h2, 16'h3, 16'h4);
        @(posedge clk); #1 wb_if.write_start = 1'b1;
        fork
            wait_done(NUM + 4, "lat_backpressure");
            begin
                @(posedge clk); #1 wb_if.write_start = 1'b0;
                @(posedge clk); #1 wb_if.wfull = 1'b1;
                @(posedge clk);
                @(posedge clk); #1 wb_if.wfull = 1'b0;
            end
        join

        // wfull raised exactly when the last element is presented
        push(16'h1, 16'h2, 16'h3, 16'h4);
        @(posedge clk); #1 wb_if.write_start = 1'b1;
        fork
            wait_done(NUM + 3, "lat_last_stall");
            begin
                @(posedge clk); #1 wb_if.write_start = 1'b0;
                repeat (3) @(posedge clk);
                #1 wb_if.wfull = 1'b1;
                @(negedge clk);
                check("stall_winc", wb_if.winc, 0);
                check("stall_wdata_hold", wb_if.wdata, 16'h4);
                @(posedge clk); #1 wb_if.wfull = 1'b0;
            end
        join

        // Level start held for 20 cycles: exactly one transfer
        d0 = done_cnt;
        w0 = wr_cnt;
        push(16'h1, 16'h2, 16'h3, 16'h4);
        @(posedge clk); #1 wb_if.write_start = 1'b1;
        fork
            wait_done(NUM + 2, "lat_level");
            begin repeat (20) @(posedge clk); #1 wb_if.write_start = 1'b0; end
        join
        repeat (3) @(negedge clk);
        check("level_done_pulses", done_cnt - d0, 1);
        check("level_writes", wr_cnt - w0, NUM);

        // Snapshot: results change one cycle after capture
        push(16'h1, 16'h2, 16'h3, 16'h4);
        @(posedge clk); #1 wb_if.write_start = 1'b1;
        fork
            wait_done(NUM + 2, "lat_snapshot");
            begin
                @(posedge clk); #1;
                wb_if.write_start = 1'b0;
                wb_if.result_bus  = '1;
            end
        join

        // Conversion, including the exact signed range limits
        load(32'h0001_2345, 32'hFFFF_0000, 32'hFFFF_8000, 32'h0000_7FFF);
`ifdef SYSTOLIC_WB_SATURATE_EN
        push(16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF);
`else
        push(16'h2345, 16'h0000, 16'h8000, 16'h7FFF);
`endif
        @(posedge clk); #1 wb_if.write_start = 1'b1;
        fork
            wait_done(NUM + 2, "lat_convert");
            begin @(posedge clk); #1 wb_if.write_start = 1'b0; end
        join

        // Reset after two writes
        load(32'h1, 32'h2, 32'h3, 32'h4);
        push(16'h1, 16'h2, 16'h3, 16'h4);
        @(posedge clk); #1 wb_if.write_start = 1'b1;
        @(posedge clk); #1 wb_if.write_start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;
        check("rst_mid_pending", sb.size(), 2);
        d0 = done_cnt;
        @(negedge clk);
        check("rst_mid_winc", wb_if.winc, 0);
        check("rst_mid_busy", wb_if.busy, 0);
        check("rst_mid_done", wb_if.write_done, 0);
        sb.delete();
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_no_done", done_cnt - d0, 0);
        check("rst_mid_idle_busy", wb_if.busy, 0);

        load(32'hA, 32'hB, 32'hC, 32'hD);
        push(16'hA, 16'hB, 16'hC, 16'hD);
        @(posedge clk); #1 wb_if.write_start = 1'b1;
        fork
            wait_done(NUM + 2, "lat_after_reset");
            begin @(posedge clk); #1 wb_if.write_start = 1'b0; end
        join

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/systolic_writeback.md
Name: systolic_writeback

Overview:
- Write stage of the TPU pipeline. Sits directly downstream of the systolic array and is driven by the top-level control FSM.
- On a write_start request it captures the array's array_size x array_size accumulator results in one snapshot.
- It then streams the results, one element per cycle, into the output FIFO, obeying wfull backpressure.
- When the last element is written it pulses write_done back to the control FSM.

Parameters:
- datawith, 16, width of each element written to the output FIFO.
- accwidth, 32, width of each accumulator result from the array; must be >= datawith.
- array_size, 2, array dimension; the block handles array_size*array_size results (NUM).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- write_start  input  1  level from control FSM, held high while in its write state.
- result_bus  input  NUM*accwidth  flattened results; element i = result_bus[i*accwidth +: accwidth], row-major (i = row*array_size + col).
- wfull  input  1  output FIFO full flag.
- winc  output  1  FIFO write strobe; one element is written per cycle winc=1.
- wdata  output  datawith  FIFO write data, valid while winc=1.
- write_done  output  1  one-cycle pulse when all NUM elements have been written.
- busy  output  1  high from capture until write_done.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; counter=0; capture buffer=0; start_q=0.
  - Outputs: winc=0, wdata=0, write_done=0, busy=0.
- start_q is a register holding the previous cycle's write_start. A start is the rising edge: write_start=1 && start_q=0.
- States: IDLE, SEND, DONE.
- IDLE:
  - On a start edge: capture all of result_bus into the buffer, counter<=0, state<=SEND.
  - Otherwise stay in IDLE. A write_start that stays high does not re-trigger.
- SEND:
  - busy=1.
  - winc = !wfull (combinational). wdata = convert(buffer[counter]), combinational from the buffer and counter.
  - At each posedge where winc=1: counter<=counter+1.
  - If counter==NUM-1 on that edge: state<=DONE.
  - While wfull=1: winc=0, counter holds, wdata holds its value.
- DONE:
  - write_done=1 and busy=1 for exactly one cycle, then state<=IDLE and counter<=0.
- Latency with no backpressure: start edge at posedge k; winc high in cycles k+1 .. k+NUM; write_done in cycle k+NUM+1.
- Each cycle with wfull=1 during SEND extends the sequence by one cycle.
- Boundary conditions:
  - write_start falling during SEND: ignored; the transfer completes.
  - New start edge during SEND or DONE: ignored. A rising edge in IDLE is required to start again.
  - result_bus changing after capture: no effect on the transfer in progress.
  - wfull rising in the same cycle as the last element: that element is not written; it is written on the first cycle with wfull=0.
  - Reset mid-transfer: returns to IDLE immediately. Elements already written to the FIFO are not retracted, and no write_done is issued.
  - Counter width: $clog2(NUM), minimum 1 bit.
- Conversion (default): wdata = low datawith bits of the accumulator (two's-complement truncation).

Optional Feature:
- Macro: SYSTOLIC_WB_SATURATE_EN.
- When defined, conversion saturates the signed accumulator to the signed datawith range:
  - value > 2^(datawith-1)-1 -> 0x7FFF (datawith=16);
  - value < -2^(datawith-1) -> 0x8000;
  - otherwise the low bits pass through unchanged.
- When not defined, conversion is plain truncation. Timing and handshakes are identical in both builds.

Test Plan:
- Basic drain:
  - Stimulus: array_size=2, result_bus elements {0:0x00000001, 1:0x00000002, 2:0x00000003, 3:0x00000004}, wfull=0, write_start pulsed high.
  - Response: winc high for 4 consecutive cycles, wdata 0x0001, 0x0002, 0x0003, 0x0004; write_done one cycle later; busy low afterwards.
- Backpressure:
  - Stimulus: same as basic drain, with wfull=1 in the 2nd and 3rd SEND cycles.
  - Response: exactly 4 writes in order, no duplicates; write_done 2 cycles later than in basic drain.
- Level start held:
  - Stimulus: write_start held high for 20 cycles.
  - Response: exactly one transfer and one write_done pulse; no second transfer until write_start goes low and high again.
- Snapshot:
  - Stimulus: change result_bus to all 0xFFFFFFFF one cycle after the start edge.
  - Response: wdata still 0x0001..0x0004.
- Conversion:
  - Stimulus: element 0 = 0x00012345, element 1 = 0xFFFF0000.
  - Response, default build: wdata 0x2345, 0x0000.
  - Response, SYSTOLIC_WB_SATURATE_EN build: wdata 0x7FFF, 0x8000.
- Reset mid-transfer:
  - Stimulus: rst=0 after 2 writes.
  - Response: winc=0, busy=0, write_done never pulses. After release, a new start edge produces all 4 writes starting from element 0.
